pht_ctr_table: RTL and testbench
================================

# pht_ctr_table

Parametrised pattern history table of saturating counters for the branch predictor, indexed by the predictor's hashed index. It replaces flop-array reset with a table-initialisation sweep, so storage maps to synchronous RAM. Reads are registered, and updates use a two-stage read-modify-write pipeline with forwarding. It sits in the fetch-stage predictor: the read port serves prediction, and the update port is driven from branch resolution.

## Interface
- INDEX_WIDTH, 10, table index width; TABLE_SIZE = 2**INDEX_WIDTH entries.
- CTR_WIDTH, 2, counter width per entry; must be >= 1.
- INIT_VALUE, 2**(CTR_WIDTH-1)-1, value written to every entry by the init sweep (weakly not taken); must be < 2**CTR_WIDTH.

- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous table clear; restarts the init sweep.
- rd_en_i  in  1  read request.
- rd_index_i  in  INDEX_WIDTH  read index.
- update_en_i  in  1  update request.
- update_index_i  in  INDEX_WIDTH  entry to update.
- br_taken_i  in  1  resolved outcome; 1 increments the counter, 0 decrements it.
- ready_o  out  1  table initialised; requests are accepted only when this is 1.
- rd_valid_o  out  1  one-cycle pulse; read data is valid.
- rd_ctr_o  out  CTR_WIDTH  counter value read.
- br_prediction_o  out  1  MSB of rd_ctr_o.

## Operation
- Reset values: ready_o=0, rd_valid_o=0, rd_ctr_o=0, br_prediction_o=0. The FSM enters INIT with the sweep counter at 0.
- FSM states:
  - INIT: writes INIT_VALUE at the sweep index, one entry per cycle, from 0 to TABLE_SIZE-1. After writing TABLE_SIZE-1 it moves to READY.
  - READY: ready_o=1.
  - flush_i=1 in any state moves to INIT with the sweep counter at 0. The sweep counter wraps only through flush or reset.
- Requests arriving while ready_o=0 are dropped silently. A dropped read produces no rd_valid_o pulse. A dropped update leaves the table unchanged.
- Flush or reset drops any updates in flight; no write from them reaches the table.
- Update arithmetic:
  - br_taken_i=1: new = min(old+1, 2**CTR_WIDTH-1).
  - br_taken_i=0: new = max(old-1, 0).
  - All arithmetic is CTR_WIDTH bits wide with no wrap.
- Update pipeline:
  - U1 registers the index and outcome, and issues the RAM read.
  - U2 selects the old value, computes the new value, and writes it.
  - If U1's index matches U2's index, U1 takes U2's new value instead of the RAM data.
  - Net effect: any sequence of accepted updates, at any spacing, gives the same result as applying them strictly in order.
- Read data is held between pulses. rd_ctr_o and br_prediction_o change only on a cycle where rd_valid_o=1.

## Timing
- Init latency: ready_o rises TABLE_SIZE cycles after rst_i deassertion, or after the cycle in which flush_i is sampled high. ready_o falls in the cycle after flush_i is sampled.
- Read latency: 1 cycle. A read accepted in cycle T gives rd_valid_o=1 in T+1, with the data.
- Update commit: an update accepted in T is written at the end of T+1. Reads accepted in T+2 or later see it.
- A read accepted in cycle T to the same index as an update accepted in T returns the pre-update value.
- A read accepted in T+1 to the same index as the update committing in T+1 depends on the macro (see Configuration).
- One read and one update may be accepted every cycle, simultaneously.

## Configuration
- PHT_RD_BYPASS_EN
  - Defined: a read to the index being written by U2 in the same cycle returns U2's new value (write-first).
  - Undefined: that read returns the pre-update value (read-first), and the bypass mux is not built.
  - Update-to-update forwarding is always present, with or without the macro.

## Test plan
All scenarios use INDEX_WIDTH=4, CTR_WIDTH=2, INIT_VALUE=1.
1. Reset release:
   - ready_o=0 for 16 cycles, then 1.
   - Read all 16 indices -> each gives rd_ctr_o=1 and br_prediction_o=0, each one cycle after its request.
2. Saturation:
   - 4 taken updates to index 3, spaced 3 cycles apart -> reads give 2, 3, 3, 3; br_prediction_o=1.
   - Then 5 not-taken updates -> final rd_ctr_o=0.
3. Forwarding: taken updates to index 5 on 2 consecutive cycles, starting from 1 -> a read in the third cycle after the second update gives rd_ctr_o=3.
4. Bypass: taken update to index 7 in cycle T, read of index 7 in T+1 -> rd_ctr_o=2 with PHT_RD_BYPASS_EN defined, 1 without. A read in T+2 gives 2 in both builds.
5. Flush mid-operation:
   - Taken update to index 2, then flush_i in the next cycle -> ready_o=0 from the following cycle for 16 cycles.
   - Index 2 then reads 1.
   - Updates and reads issued during the sweep are dropped, and rd_valid_o stays 0.
6. Async reset during READY after several updates: assert rst_i mid-cycle -> outputs go to 0 immediately; after the sweep, all entries read 1.

Source files
------------

// File: rtl/pht_ctr_table.sv
// Pattern history table of saturating counters, RAM-backed, cleared by an init sweep (reset or flush_i).
// Latency: read 1 cycle; an update commits at the end of the cycle after it is accepted, with U2->U1 forwarding.
// Backpressure: none; requests while ready_o=0 are dropped. Optional macro PHT_RD_BYPASS_EN: write-first read bypass of U2.
module pht_ctr_table #(
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned INIT_VALUE  = 2**(CTR_WIDTH-1)-1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   rd_en_i,
  input  logic [INDEX_WIDTH-1:0] rd_index_i,
  input  logic                   update_en_i,
  input  logic [INDEX_WIDTH-1:0] update_index_i,
  input  logic                   br_taken_i,
  output logic                   ready_o,
  output logic                   rd_valid_o,
  output logic [CTR_WIDTH-1:0]   rd_ctr_o,
  output logic                   br_prediction_o
);

  localparam int unsigned TABLE_SIZE = 2**INDEX_WIDTH;

  typedef logic [CTR_WIDTH-1:0]   ctr_t;
  typedef logic [INDEX_WIDTH-1:0] idx_t;

  localparam ctr_t CTR_MAX    = '1;
  localparam ctr_t CTR_MIN    = '0;
  localparam ctr_t CTR_ONE    = ctr_t'(1);
  localparam ctr_t CTR_INIT   = ctr_t'(INIT_VALUE);
  localparam idx_t SWEEP_LAST = '1;
  localparam idx_t SWEEP_ONE  = idx_t'(1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e state_q, state_d;
  idx_t   sweep_q, sweep_d;

  ctr_t   mem [TABLE_SIZE];

  logic   rd_acc;
  logic   upd_acc;
  logic   fwd_hit;
  logic   u2_vld_q;
  idx_t   u2_idx_q;
  logic   u2_taken_q;
  ctr_t   u2_old_q;
  ctr_t   u2_new;
  logic   u2_we;
  ctr_t   u1_old;

  logic   mem_we;
  idx_t   mem_waddr;
  ctr_t   mem_wdata;

  ctr_t   rd_data;
  logic   rd_valid_q;
  ctr_t   rd_ctr_q;

  // Init/ready control
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        // Counter parks at the last index; only flush or reset bring it back to 0.
        if (sweep_q == SWEEP_LAST) begin
          state_d = ST_READY;
        end else begin
          sweep_d = sweep_q + SWEEP_ONE;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
    if (flush_i) begin
      state_d = ST_INIT;
      sweep_d = '0;
    end
  end

  assign ready_o = (state_q == ST_READY);
  assign rd_acc  = rd_en_i & ready_o;
  assign upd_acc = update_en_i & ready_o & ~flush_i;

  // U2: saturating update of the old value captured by U1
  always_comb begin
    u2_new = u2_old_q;
    if (u2_taken_q) begin
      if (u2_old_q != CTR_MAX) u2_new = u2_old_q + CTR_ONE;
    end else begin
      if (u2_old_q != CTR_MIN) u2_new = u2_old_q - CTR_ONE;
    end
  end

  // A flush in the commit cycle kills the write; the sweep owns the table from then on.
  assign u2_we   = u2_vld_q & ~flush_i;
  assign fwd_hit = u2_vld_q & (u2_idx_q == update_index_i);
  assign u1_old  = fwd_hit ? u2_new : mem[update_index_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      u2_vld_q   <= 1'b0;
      u2_idx_q   <= '0;
      u2_taken_q <= 1'b0;
      u2_old_q   <= '0;
    end else begin
      u2_vld_q <= upd_acc;
      if (upd_acc) begin
        u2_idx_q   <= update_index_i;
        u2_taken_q <= br_taken_i;
        u2_old_q   <= u1_old;
      end
    end
  end

  // Single write port shared by the sweep and U2; U2 is never valid during INIT.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = u2_idx_q;
    mem_wdata = u2_new;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_q;
      mem_wdata = CTR_INIT;
    end else if (u2_we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read port
  always_comb begin
    rd_data = mem[rd_index_i];
`ifdef PHT_RD_BYPASS_EN
    if (u2_we && (u2_idx_q == rd_index_i)) begin
      rd_data = u2_new;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_ctr_q   <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_ctr_q <= rd_data;
      end
    end
  end

  assign rd_valid_o      = rd_valid_q;
  assign rd_ctr_o        = rd_ctr_q;
  assign br_prediction_o = rd_ctr_q[CTR_WIDTH-1];

  a_single_writer: assert property (@(posedge clk_i) disable iff (rst_i)
    !((state_q == ST_INIT) && u2_vld_q));

endmodule

// File: tb/tb_pht_ctr_table.sv
// Randomised scoreboard bench for pht_ctr_table (INDEX_WIDTH=4, CTR_WIDTH=2, INIT_VALUE=1).
// Expected reads come from an ordered list of accepted updates applied to a plain array.
module tb_pht_ctr_table;

  localparam int IW   = 4;
  localparam int CW   = 2;
  localparam int IV   = 1;
  localparam int TS   = 1 << IW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          rd_en_i;
  logic [IW-1:0] rd_index_i;
  logic          update_en_i;
  logic [IW-1:0] update_index_i;
  logic          br_taken_i;
  logic          ready_o;
  logic          rd_valid_o;
  logic [CW-1:0] rd_ctr_o;
  logic          br_prediction_o;

  pht_ctr_table #(.INDEX_WIDTH(IW), .CTR_WIDTH(CW), .INIT_VALUE(IV)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .rd_en_i        (rd_en_i),
    .rd_index_i     (rd_index_i),
    .update_en_i    (update_en_i),
    .update_index_i (update_index_i),
    .br_taken_i     (br_taken_i),
    .ready_o        (ready_o),
    .rd_valid_o     (rd_valid_o),
    .rd_ctr_o       (rd_ctr_o),
    .br_prediction_o(br_prediction_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int idx; bit taken; int cyc;} upd_t;
  typedef struct {int val; int cyc;} rd_exp_t;

  upd_t    pend[$];
  rd_exp_t exp_q[$];
  int      tbl[TS];
  int      init_left;
  int      cyc = 0;
  int      n_vec = 0;
  int      n_err = 0;
  int      last_exp = 0;
  rd_exp_t mon_e;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int sat_step(input int v, input bit taken);
    if (taken) return (v < CMAX) ? v + 1 : CMAX;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TS; i++) tbl[i] = IV;
    pend.delete();
    init_left = TS;
  endtask

  // Apply, in order, every accepted update issued at or before cycle 'upto'.
  task automatic drain(input int upto);
    upd_t u;
    while (pend.size() > 0 && pend[0].cyc <= upto) begin
      u = pend.pop_front();
      tbl[u.idx] = sat_step(tbl[u.idx], u.taken);
    end
  endtask

  // One cycle of stimulus, entered and left at a falling edge.
  task automatic step(input bit rd, input int ri, input bit up, input int ui, input bit tk, input bit fl);
    bit rdy_exp;
    rdy_exp = (init_left == 0);
    chk("ready", int'(ready_o), int'(rdy_exp));
    rd_en_i        = rd;
    rd_index_i     = IW'(ri);
    update_en_i    = up;
    update_index_i = IW'(ui);
    br_taken_i     = tk;
    flush_i        = fl;
    if (rd && rdy_exp) begin
`ifdef PHT_RD_BYPASS_EN
      drain(cyc - 1);
`else
      drain(cyc - 2);
`endif
      exp_q.push_back('{tbl[ri], cyc + 1});
    end
    if (up && rdy_exp && !fl) pend.push_back('{ui, tk, cyc});
    if (fl) model_clear();
    else if (init_left > 0) init_left--;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every read pulse must match the oldest expectation; data holds otherwise.
  always @(posedge clk_i) begin
    #1;
    if (rst_i) begin
      last_exp = 0;
    end else if (rd_valid_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected at cycle %0d: got rd_valid_o=1, expected no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_cycle", cyc, mon_e.cyc);
        chk("rd_ctr", int'(rd_ctr_o), mon_e.val);
        chk("rd_pred", int'(br_prediction_o), (mon_e.val >> (CW - 1)) & 1);
        last_exp = mon_e.val;
      end
    end else begin
      chk("rd_hold", int'(rd_ctr_o), last_exp);
    end
  end

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    rd_en_i = 1'b0;
    rd_index_i = '0;
    update_en_i = 1'b0;
    update_index_i = '0;
    br_taken_i = 1'b0;
    model_clear();
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_ready", int'(ready_o), 0);
      chk("rst_rd_valid", int'(rd_valid_o), 0);
      chk("rst_rd_ctr", int'(rd_ctr_o), 0);
    end
    rst_i = 1'b0;

    // Init sweep then read every entry
    idle(TS + 1);
    for (int i = 0; i < TS; i++) step(1, i, 0, 0, 0, 0);
    idle(2);

    // Saturation up then down on index 3
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 3, 1, 0);
      idle(1);
      step(1, 3, 0, 0, 0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 3, 0, 0);
      idle(1);
      step(1, 3, 0, 0, 0, 0);
    end

    // Back-to-back updates on index 5
    step(0, 0, 1, 5, 1, 0);
    step(0, 0, 1, 5, 1, 0);
    idle(2);
    step(1, 5, 0, 0, 0, 0);

    // Read right behind an update on index 7
    step(0, 0, 1, 7, 1, 0);
    step(1, 7, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0);
    idle(2);

    // Flush with an update in flight; requests during the sweep must vanish
    step(0, 0, 1, 2, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < TS; i++) step(1, i, 1, 2, 1, 0);
    step(1, 2, 0, 0, 0, 0);
    idle(2);

    // Random traffic, biased to a few indices to provoke hazards
    for (int i = 0; i < 600; i++) begin
      bit fl, rd, up, tk;
      int ri, ui;
      fl = ($urandom_range(0, 199) == 0);
      rd = !fl && ($urandom_range(0, 2) != 0);
      up = !fl && ($urandom_range(0, 2) != 0);
      tk = $urandom_range(0, 1) == 1;
      ri = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, TS - 1);
      ui = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, TS - 1);
      step(rd, ri, up, ui, tk, fl);
    end
    idle(TS + 2);

    // Async reset mid-cycle after some updates
    for (int k = 0; k < 4; k++) step(0, 0, 1, k, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(3);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_ready", int'(ready_o), 0);
    chk("arst_rd_valid", int'(rd_valid_o), 0);
    chk("arst_rd_ctr", int'(rd_ctr_o), 0);
    chk("arst_pred", int'(br_prediction_o), 0);
    model_clear();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    idle(TS);
    for (int i = 0; i < TS; i++) step(1, i, 0, 0, 0, 0);
    idle(3);

    chk("pending_reads", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
